vector_rf_mp: RTL and testbench

//  Multi-read-port vector register file for the vector unit.

---
 rtl/vector_rf_mp.sv | 154 +++++++++++++++
 tb/tb_vector_rf_mp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_rf_mp.sv
// vector_rf_mp: multi-read-port vector register file for the vector unit.
// A sweep clears every entry to zero after reset and on request. The storage array itself has no
// reset. Each read port is registered with a latency of one cycle. The single write port merges
// new data into an entry under per-sub-element enables.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   o_ready          1 once the sweep has finished and accesses are accepted
//   i_clear_req      start a new zero sweep (only sampled while ready)
//   i_rd_en/addr     per-port read enable and address
//   o_rd_data        per-port registered read data
//   i_wr_en/addr     write enable and address
//   i_wr_mask        sub-element enables; mask bit m covers data bits [m*SUB +: SUB]
//   i_wr_data        write data (element 0 sits at the MSB end)
module vector_rf_mp #(
  parameter int unsigned NUM_ELEMS           = 8,
  parameter int unsigned ELEM_SIZE           = 16,
  parameter int unsigned ENABLES_PER_ELEMENT = 4,
  parameter int unsigned VRF_SIZE            = 32,
  parameter int unsigned NUM_READ_PORTS      = 2,
  localparam int unsigned W   = NUM_ELEMS * ELEM_SIZE,
  localparam int unsigned AW  = $clog2(VRF_SIZE),
  localparam int unsigned SUB = ELEM_SIZE / ENABLES_PER_ELEMENT,
  localparam int unsigned MW  = NUM_ELEMS * ENABLES_PER_ELEMENT
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  output logic                               o_ready,
  input  logic                               i_clear_req,
  input  logic [NUM_READ_PORTS-1:0]          i_rd_en,
  input  logic [NUM_READ_PORTS-1:0][AW-1:0]  i_rd_addr,
  output logic [NUM_READ_PORTS-1:0][W-1:0]   o_rd_data,
  input  logic                               i_wr_en,
  input  logic [AW-1:0]                      i_wr_addr,
  input  logic [MW-1:0]                      i_wr_mask,
  input  logic [W-1:0]                       i_wr_data
);

  if (ELEM_SIZE % ENABLES_PER_ELEMENT != 0) begin : g_bad_enables
    $error("ELEM_SIZE must be a multiple of ENABLES_PER_ELEMENT");
  end
  if (VRF_SIZE < 2) begin : g_bad_size
    $error("VRF_SIZE must be at least 2");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_ports
    $error("NUM_READ_PORTS must be at least 1");
  end

  localparam logic [AW-1:0] LastPtr = AW'(VRF_SIZE - 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e                             r_state, w_state_next;
  logic [AW-1:0]                      r_init_ptr, w_init_ptr_next;
  logic [W-1:0]                       r_regs [VRF_SIZE];
  logic [NUM_READ_PORTS-1:0][W-1:0]   r_rd_data;
  logic [NUM_READ_PORTS-1:0][W-1:0]   w_rd_next;
  logic [W-1:0]                       w_bitmask;
  logic [W-1:0]                       w_wr_old;
  logic [W-1:0]                       w_merged;
  logic                               w_wr_addr_ok;
  logic                               w_wr_fire;

  // Only a non-power-of-two depth can produce out-of-range addresses.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < VRF_SIZE);
  endfunction

  always_comb begin
    w_bitmask = '0;
    for (int m = 0; m < MW; m++) begin
      w_bitmask[m*SUB +: SUB] = {SUB{i_wr_mask[m]}};
    end
  end

  // A clear request in the same cycle discards the write.
  assign w_wr_addr_ok = addr_ok(i_wr_addr);
  assign w_wr_fire    = (r_state == StReady) && i_wr_en && !i_clear_req && w_wr_addr_ok;
  assign w_wr_old     = w_wr_addr_ok ? r_regs[i_wr_addr] : '0;
  assign w_merged     = (i_wr_data & w_bitmask) | (w_wr_old & ~w_bitmask);

  always_comb begin
    w_state_next    = r_state;
    w_init_ptr_next = r_init_ptr;
    case (r_state)
      StInit: begin
        if (r_init_ptr == LastPtr) begin
          w_state_next    = StReady;
          w_init_ptr_next = '0;
        end else begin
          w_init_ptr_next = r_init_ptr + 1'b1;
        end
      end
      StReady: begin
        if (i_clear_req) begin
          w_state_next    = StInit;
          w_init_ptr_next = '0;
        end
      end
      default: begin
        w_state_next    = StInit;
        w_init_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StInit;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_ptr <= w_init_ptr_next;
    end
  end

  // The storage array has no reset. It is zeroed one entry per cycle by the sweep.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == StInit) begin
        r_regs[r_init_ptr] <= '0;
      end else if (w_wr_fire) begin
        r_regs[i_wr_addr] <= w_merged;
      end
    end
  end

  // Reads are write-first. A same-address write forwards its merged value.
  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      w_rd_next[p] = '0;
      if (addr_ok(i_rd_addr[p])) begin
        w_rd_next[p] = (w_wr_fire && (i_rd_addr[p] == i_wr_addr)) ? w_merged
                                                                 : r_regs[i_rd_addr[p]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == StInit)) begin
      r_rd_data <= '0;
    end else begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (i_rd_en[p]) begin
          r_rd_data[p] <= w_rd_next[p];
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_ready   = (r_state == StReady);

endmodule

// File: tb/tb_vector_rf_mp.sv
// Directed bench for vector_rf_mp with its default parameters (8x16-bit elements, 32 registers,
// 2 read ports). A table covers the single-cycle read/write cases. Hand-written sequences cover
// the sweep timing, clear and mid-sweep reset.
module tb_vector_rf_mp;

  localparam int W  = 128;
  localparam int AW = 5;
  localparam int MW = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                ready;
  logic                clear_req;
  logic [1:0]          rd_en;
  logic [1:0][AW-1:0]  rd_addr;
  logic [1:0][W-1:0]   rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [MW-1:0]       wr_mask;
  logic [W-1:0]        wr_data;

  vector_rf_mp dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .o_ready    (ready),
    .i_clear_req(clear_req),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_mask  (wr_mask),
    .i_wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [MW-1:0] wmask;
    logic [W-1:0]  wdata;
    logic [1:0]    ren;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    chk;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
  } vec_t;

  localparam logic [W-1:0] D2  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [W-1:0] D3  = 128'hF123_4567_89AB_CDEF_0011_2233_4455_667F;
  localparam logic [W-1:0] DA  = {8{16'hAAAA}};
  localparam logic [W-1:0] D5  = {8{16'h5555}};
  localparam logic [W-1:0] D7B = 128'h5555_5555_5555_5555_0000_0000_0000_0000;
  localparam logic [W-1:0] D1  = {32{4'h1}};
  localparam logic [W-1:0] D1M = 128'h0000_1111_0000_1111_0000_1111_0000_1111;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_mask   = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_addr   = '0;
    clear_req = 1'b0;
  endtask

  // Counts edges until ready rises, bounded so a stuck DUT still reaches the summary.
  task automatic wait_ready(input string name, input int exp_cycles);
    int cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    check(name, W'(cnt), W'(exp_cycles));
  endtask

  task automatic read2(input string name, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] e0, input logic [W-1:0] e1);
    idle();
    rd_en      = 2'b11;
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    step();
    check({name, "_p0"}, rd_data[0], e0);
    check({name, "_p1"}, rd_data[1], e1);
    idle();
  endtask

  function automatic vec_t mk(input logic wen, input logic [AW-1:0] waddr,
                              input logic [MW-1:0] wmask, input logic [W-1:0] wdata,
                              input logic [1:0] ren, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a1, input logic [1:0] chk,
                              input logic [W-1:0] e0, input logic [W-1:0] e1);
    vec_t v;
    v.wen = wen; v.waddr = waddr; v.wmask = wmask; v.wdata = wdata;
    v.ren = ren; v.a0 = a0; v.a1 = a1; v.chk = chk; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(1'b1, 5'd5, 32'hFFFF_FFFF, D2,  2'b00, 5'd0, 5'd0, 2'b00, '0, '0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,         '0,  2'b01, 5'd5, 5'd0, 2'b01, D2, '0);
    // Port 0 idle holds D2; port 1 sees the merged write on the same cycle.
    tbl[2]  = mk(1'b1, 5'd5, 32'h8000_0001, '1,  2'b10, 5'd0, 5'd5, 2'b11, D2, D3);
    tbl[3]  = mk(1'b0, 5'd0, 32'h0,         '0,  2'b01, 5'd5, 5'd0, 2'b01, D3, '0);
    tbl[4]  = mk(1'b1, 5'd7, 32'hFFFF_FFFF, DA,  2'b11, 5'd7, 5'd7, 2'b11, DA, DA);
    tbl[5]  = mk(1'b1, 5'd7, 32'hFFFF_FFFF, D5,  2'b01, 5'd7, 5'd7, 2'b11, D5, DA);
    tbl[6]  = mk(1'b1, 5'd7, 32'h0000_FFFF, '0,  2'b01, 5'd7, 5'd7, 2'b11, D7B, DA);
    tbl[7]  = mk(1'b1, 5'd7, 32'h0,         D2,  2'b01, 5'd7, 5'd7, 2'b11, D7B, DA);
    tbl[8]  = mk(1'b0, 5'd0, 32'h0,         '0,  2'b10, 5'd0, 5'd7, 2'b10, '0, D7B);
    tbl[9]  = mk(1'b1, 5'd1, 32'h0F0F_0F0F, D1,  2'b11, 5'd1, 5'd9, 2'b11, D1M, '0);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,         '0,  2'b10, 5'd0, 5'd1, 2'b10, D1M, D1M);

    // Reset state.
    idle();
    reset = 1'b1;
    step();
    check("reset_ready", W'(ready), W'(0));
    check("reset_rd0", rd_data[0], '0);
    check("reset_rd1", rd_data[1], '0);
    reset = 1'b0;

    // The sweep must ignore accesses. Write r9 throughout and expect it to read back as zero.
    wr_en      = 1'b1;
    wr_addr    = 5'd9;
    wr_mask    = '1;
    wr_data    = '1;
    rd_en      = 2'b11;
    rd_addr[0] = 5'd9;
    rd_addr[1] = 5'd31;
    wait_ready("init_cycles", 32);
    idle();
    check("init_rd0_zero", rd_data[0], '0);

    for (int i = 0; i < 32; i++) begin
      read2($sformatf("t1_r%0d", i), AW'(i), AW'(31 - i), '0, '0);
    end

    // Table-driven read/write cases.
    for (int k = 0; k < 11; k++) begin
      wr_en      = tbl[k].wen;
      wr_addr    = tbl[k].waddr;
      wr_mask    = tbl[k].wmask;
      wr_data    = tbl[k].wdata;
      rd_en      = tbl[k].ren;
      rd_addr[0] = tbl[k].a0;
      rd_addr[1] = tbl[k].a1;
      clear_req  = 1'b0;
      step();
      if (tbl[k].chk[0]) check($sformatf("vec%0d_p0", k), rd_data[0], tbl[k].e0);
      if (tbl[k].chk[1]) check($sformatf("vec%0d_p1", k), rd_data[1], tbl[k].e1);
    end
    idle();

    // A clear request arrives together with a write to r3. The write is lost and the sweep restarts.
    clear_req  = 1'b1;
    wr_en      = 1'b1;
    wr_addr    = 5'd3;
    wr_mask    = '1;
    wr_data    = D2;
    rd_en      = 2'b01;
    rd_addr[0] = 5'd5;
    step();
    idle();
    check("clear_ready_drop", W'(ready), W'(0));
    wait_ready("clear_cycles", 32);
    check("clear_rd0_zero", rd_data[0], '0);
    read2("t6_r3_r5", 5'd3, 5'd5, '0, '0);
    read2("t6_r7_r1", 5'd7, 5'd1, '0, '0);

    // Reset arrives mid-sweep at ptr 10. The full 32-cycle sweep starts again.
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_mask = '1;
    wr_data = DA;
    step();
    idle();
    read2("pre_r20", 5'd20, 5'd20, DA, DA);
    clear_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    check("mid_init_not_ready", W'(ready), W'(0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready("reset_mid_init_cycles", 32);
    read2("post_r20", 5'd20, 5'd5, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
